axis_fifo_packer: RTL

//  Upstream stage of the 45-bit stream FIFO: accepts an AXI-Stream slave beat and packs

---
 rtl/fsic_axis_pkg.sv | 23 ++
 rtl/axis_skid_buf.sv | 78 +++++++
 rtl/axis_fifo_packer.sv | 77 +++++++
 3 files changed

// File: rtl/fsic_axis_pkg.sv
// Shared AXI-Stream FIFO definitions: packed-word field offsets and skid buffer state encoding.
package fsic_axis_pkg;

  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned AXIS_STRB_W = AXIS_DATA_W / 8;
  localparam int unsigned AXIS_USER_W = 2;
  localparam int unsigned AXIS_ID_W   = 2;
  localparam int unsigned AXIS_WIDTH  = AXIS_DATA_W + 2 * AXIS_STRB_W + AXIS_USER_W + AXIS_ID_W + 1;

  localparam int unsigned TDATA_LSB = 0;
  localparam int unsigned TSTRB_LSB = TDATA_LSB + AXIS_DATA_W;
  localparam int unsigned TKEEP_LSB = TSTRB_LSB + AXIS_STRB_W;
  localparam int unsigned TUSER_LSB = TKEEP_LSB + AXIS_STRB_W;
  localparam int unsigned TID_LSB   = TUSER_LSB + AXIS_USER_W;
  localparam int unsigned TLAST_BIT = TID_LSB + AXIS_ID_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// Generic 2-entry skid buffer: main register drives the output, skid register absorbs the one
// beat that may arrive while the registered ready is still high during a downstream stall.
module axis_skid_buf
  import fsic_axis_pkg::*;
#(
  parameter int unsigned WIDTH = AXIS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q;
  logic             accept;
  logic             emit;

  assign accept = in_vld & rdy_q;
  assign emit   = (state_q != EMPTY) & out_rdy;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (accept && !emit) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (emit && !accept) begin
          state_d = EMPTY;
        end else if (accept && emit) begin
          main_d = in_data;
        end
      end
      // rdy_q is low here, so no accept can coincide with the emit.
      FULL: begin
        if (emit) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  assign in_rdy   = rdy_q;
  assign out_vld  = (state_q != EMPTY);
  assign out_data = main_q;

endmodule

// File: rtl/axis_fifo_packer.sv
// AXI-Stream slave to FIFO write port: packs beat fields into one word, drops null beats.
// Optional frame counter on pkt_cnt enabled by defining AXIS_PACKER_PKT_CNT_EN.
module axis_fifo_packer
  import fsic_axis_pkg::*;
#(
  parameter int unsigned DATA_W = AXIS_DATA_W,
  parameter int unsigned USER_W = AXIS_USER_W,
  parameter int unsigned ID_W   = AXIS_ID_W,
  parameter int unsigned WIDTH  = AXIS_WIDTH
) (
  input  logic                axis_clk,
  input  logic                axi_reset,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tstrb,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic [USER_W-1:0]   s_tuser,
  input  logic [ID_W-1:0]     s_tid,
  input  logic                s_tlast,
  output logic                w_vld,
  input  logic                w_rdy,
  output logic [WIDTH-1:0]    data_in,
  output logic [15:0]         pkt_cnt
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [WIDTH-1:0] word;
  logic             null_beat;
  logic             push;

  always_comb begin
    word                           = '0;
    word[TDATA_LSB +: DATA_W]      = s_tdata;
    word[TSTRB_LSB +: STRB_W]      = s_tstrb;
    word[TKEEP_LSB +: STRB_W]      = s_tkeep;
    word[TUSER_LSB +: USER_W]      = s_tuser;
    word[TID_LSB +: ID_W]          = s_tid;
    word[TLAST_BIT]                = s_tlast;
  end

  // Null beats still see s_tready and are consumed, they just never reach the buffer.
  // A keep-less tlast beat is kept so the frame boundary survives.
  assign null_beat = (s_tkeep == '0) && !s_tlast;
  assign push      = s_tvalid & ~null_beat;

  axis_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk      (axis_clk),
    .rst      (axi_reset),
    .in_vld   (push),
    .in_rdy   (s_tready),
    .in_data  (word),
    .out_vld  (w_vld),
    .out_rdy  (w_rdy),
    .out_data (data_in)
  );

`ifdef AXIS_PACKER_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge axis_clk) begin
    if (axi_reset) begin
      pkt_cnt_q <= '0;
    end else if (w_vld && w_rdy && data_in[TLAST_BIT]) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = 16'h0;
`endif

endmodule
